// File: rtl/reorder_buffer_pkg.sv
// Shared sizing, types and helpers for the reorder buffer.
// Lane, port and index widths are fixed here so the decoder and execution units agree on them.
package reorder_buffer_pkg;

    localparam int ROB_DEPTH    = 32;
    localparam int ROB_ADDR_W   = $clog2(ROB_DEPTH);
    localparam int PHYS_REGS    = 64;
    localparam int PR_ADDR_W    = $clog2(PHYS_REGS);
    localparam int ALLOC_W      = 4;
    localparam int CMPLT_W      = 4;
    localparam int COMMIT_W     = 6;
    localparam int CNT_W        = ROB_ADDR_W + 1;
    localparam int COMMIT_CNT_W = 3;

    typedef logic [ROB_ADDR_W-1:0]   rob_idx_t;
    typedef logic [PR_ADDR_W-1:0]    preg_t;
    typedef logic [CNT_W-1:0]        rob_cnt_t;
    typedef logic [COMMIT_CNT_W-1:0] commit_cnt_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        preg_t old_alias;
    } rob_entry_t;

    // alloc_valid is thermometer coded, so a plain popcount gives the lane count.
    function automatic commit_cnt_t popcount_alloc(input logic [ALLOC_W-1:0] v);
        commit_cnt_t n;
        n = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            n = n + commit_cnt_t'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reorder_buffer_commit_scan.sv
// commit_scan: length of the run of ready entries starting at the oldest slot.
// The input is already rotated so bit 0 is the head entry; the result saturates at COMMIT_W.
module reorder_buffer_commit_scan
    import reorder_buffer_pkg::*;
(
    input  logic [COMMIT_W-1:0] ready_i,
    output commit_cnt_t         run_len_o
);

    logic run;

    always_comb begin
        run_len_o = '0;
        run       = 1'b1;
        for (int j = 0; j < COMMIT_W; j++) begin
            run = run & ready_i[j];
            if (run) begin
                run_len_o = commit_cnt_t'(j + 1);
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement tracker: allocates ROB slots to renamed micro-ops, marks them done on
// completion, and retires up to COMMIT_W oldest done entries per cycle, returning their old aliases.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             rst_i,
    output logic [ALLOC_W*ROB_ADDR_W-1:0]    rob_entries_o,
    input  logic [ALLOC_W-1:0]               alloc_valid_i,
    input  logic [ALLOC_W*PR_ADDR_W-1:0]     alloc_old_alias_i,
    output logic                             alloc_ready_o,
    input  logic [CMPLT_W-1:0]               cmplt_valid_i,
    input  logic [CMPLT_W*ROB_ADDR_W-1:0]    cmplt_rob_id_i,
    output logic [COMMIT_W*PR_ADDR_W-1:0]    cmplt_free_regs_o,
    output logic [COMMIT_CNT_W-1:0]          commit_count_o,
    output logic [CNT_W-1:0]                 rob_count_o,
    output logic                             rob_empty_o
);

    rob_entry_t  entries_q [ROB_DEPTH];
    rob_entry_t  entries_d [ROB_DEPTH];
    rob_idx_t    head_q, head_d;
    rob_idx_t    tail_q, tail_d;
    rob_cnt_t    count_q, count_d;

    rob_idx_t    alloc_idx  [ALLOC_W];
    rob_idx_t    commit_idx [COMMIT_W];
    rob_idx_t    cmplt_idx  [CMPLT_W];
    logic [COMMIT_W-1:0] ready_rot;
    commit_cnt_t scan_len;
    commit_cnt_t commit_k;
    commit_cnt_t alloc_n;
    logic        alloc_fire;

    always_comb begin
        for (int i = 0; i < ALLOC_W; i++) begin
            alloc_idx[i] = tail_q + rob_idx_t'(i);
            rob_entries_o[i*ROB_ADDR_W +: ROB_ADDR_W] = alloc_idx[i];
        end
        for (int p = 0; p < CMPLT_W; p++) begin
            cmplt_idx[p] = cmplt_rob_id_i[p*ROB_ADDR_W +: ROB_ADDR_W];
        end
    end

    // Only the first COMMIT_W entries from head can retire, so only those are rotated.
    always_comb begin
        for (int j = 0; j < COMMIT_W; j++) begin
            commit_idx[j] = head_q + rob_idx_t'(j);
            ready_rot[j]  = entries_q[commit_idx[j]].valid & entries_q[commit_idx[j]].done;
        end
    end

    reorder_buffer_commit_scan u_commit_scan (
        .ready_i   (ready_rot),
        .run_len_o (scan_len)
    );

    always_comb begin
        if ({{(CNT_W-COMMIT_CNT_W){1'b0}}, scan_len} > count_q) begin
            commit_k = count_q[COMMIT_CNT_W-1:0];
        end else begin
            commit_k = scan_len;
        end
    end

    always_comb begin
        for (int j = 0; j < COMMIT_W; j++) begin
            if (commit_cnt_t'(j) < commit_k) begin
                cmplt_free_regs_o[j*PR_ADDR_W +: PR_ADDR_W] = entries_q[commit_idx[j]].old_alias;
            end else begin
                cmplt_free_regs_o[j*PR_ADDR_W +: PR_ADDR_W] = '0;
            end
        end
    end

    // Room is judged on the pre-commit count; this cycle's retirements do not help.
    assign alloc_ready_o  = (count_q <= rob_cnt_t'(ROB_DEPTH - ALLOC_W));
    assign alloc_n        = popcount_alloc(alloc_valid_i);
    assign alloc_fire     = alloc_ready_o && (alloc_valid_i != '0);
    assign commit_count_o = commit_k;
    assign rob_count_o    = count_q;
    assign rob_empty_o    = (count_q == '0);

    // Completions are checked against current valid bits, so a completion that lands on a slot
    // being allocated on the same edge is dropped; allocation then writes done=0 over it.
    always_comb begin
        entries_d = entries_q;
        for (int p = 0; p < CMPLT_W; p++) begin
            if (cmplt_valid_i[p] && entries_q[cmplt_idx[p]].valid) begin
                entries_d[cmplt_idx[p]].done = 1'b1;
            end
        end
        for (int j = 0; j < COMMIT_W; j++) begin
            if (commit_cnt_t'(j) < commit_k) begin
                entries_d[commit_idx[j]] = '0;
            end
        end
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_fire && (commit_cnt_t'(i) < alloc_n)) begin
                entries_d[alloc_idx[i]].valid     = 1'b1;
                entries_d[alloc_idx[i]].done      = 1'b0;
                entries_d[alloc_idx[i]].old_alias = alloc_old_alias_i[i*PR_ADDR_W +: PR_ADDR_W];
            end
        end
    end

    always_comb begin
        head_d  = head_q + rob_idx_t'(commit_k);
        tail_d  = tail_q;
        count_d = count_q - rob_cnt_t'(commit_k);
        if (alloc_fire) begin
            tail_d  = tail_q + rob_idx_t'(alloc_n);
            count_d = count_q + rob_cnt_t'(alloc_n) - rob_cnt_t'(commit_k);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, completion ordering, full/wrap cases and reset.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] rob_entries;
    logic [3:0]  alloc_valid;
    logic [23:0] alloc_old_alias;
    logic        alloc_ready;
    logic [3:0]  cmplt_valid;
    logic [19:0] cmplt_rob_id;
    logic [35:0] cmplt_free_regs;
    logic [2:0]  commit_count;
    logic [5:0]  rob_count;
    logic        rob_empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rob_entries_o     (rob_entries),
        .alloc_valid_i     (alloc_valid),
        .alloc_old_alias_i (alloc_old_alias),
        .alloc_ready_o     (alloc_ready),
        .cmplt_valid_i     (cmplt_valid),
        .cmplt_rob_id_i    (cmplt_rob_id),
        .cmplt_free_regs_o (cmplt_free_regs),
        .commit_count_o    (commit_count),
        .rob_count_o       (rob_count),
        .rob_empty_o       (rob_empty)
    );

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            assert ((alloc_valid & (alloc_valid + 4'd1)) == 4'd0)
                else $error("alloc_valid not thermometer coded: %b", alloc_valid);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        alloc_valid = 4'd0;
        cmplt_valid = 4'd0;
    endtask

    task automatic drive_alloc(input int n, input logic [5:0] a0, input logic [5:0] a1,
                               input logic [5:0] a2, input logic [5:0] a3);
        alloc_valid     = 4'((1 << n) - 1);
        alloc_old_alias = {a3, a2, a1, a0};
    endtask

    task automatic drive_cmplt(input logic [3:0] v, input logic [4:0] i0, input logic [4:0] i1,
                               input logic [4:0] i2, input logic [4:0] i3);
        cmplt_valid  = v;
        cmplt_rob_id = {i3, i2, i1, i0};
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_alloc(4, 6'd9, 6'd9, 6'd9, 6'd9);
        drive_cmplt(4'hF, 5'd0, 5'd1, 5'd2, 5'd3);
        tick();
        rst = 1'b0;
        idle();
        if (rob_entries !== {5'd3, 5'd2, 5'd1, 5'd0}) begin
            bad++; $display("FAIL reset_entries got=%h want=%h", rob_entries, {5'd3, 5'd2, 5'd1, 5'd0});
        end
        total++;
        if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", alloc_ready); end
        total++;
        if (cmplt_free_regs !== 36'd0) begin bad++; $display("FAIL reset_free got=%h want=0", cmplt_free_regs); end
        total++;
        if (commit_count !== 3'd0) begin bad++; $display("FAIL reset_commit got=%0d want=0", commit_count); end
        total++;
        if (rob_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", rob_count); end
        total++;
        if (rob_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", rob_empty); end
        total++;
    endtask

    task automatic test_basic;
        do_reset();
        drive_alloc(4, 6'd5, 6'd6, 6'd7, 6'd8);
        tick();
        idle();
        if (rob_count !== 6'd4) begin bad++; $display("FAIL basic_count got=%0d want=4", rob_count); end
        total++;
        if (rob_entries !== {5'd7, 5'd6, 5'd5, 5'd4}) begin
            bad++; $display("FAIL basic_entries got=%h want=%h", rob_entries, {5'd7, 5'd6, 5'd5, 5'd4});
        end
        total++;
        if (commit_count !== 3'd0) begin bad++; $display("FAIL basic_early_commit got=%0d want=0", commit_count); end
        total++;
        drive_cmplt(4'hF, 5'd0, 5'd1, 5'd2, 5'd3);
        tick();
        idle();
        if (commit_count !== 3'd4) begin bad++; $display("FAIL basic_commit got=%0d want=4", commit_count); end
        total++;
        if (cmplt_free_regs !== {6'd0, 6'd0, 6'd8, 6'd7, 6'd6, 6'd5}) begin
            bad++; $display("FAIL basic_free got=%h want=%h", cmplt_free_regs, {6'd0, 6'd0, 6'd8, 6'd7, 6'd6, 6'd5});
        end
        total++;
        tick();
        if (rob_empty !== 1'b1 || commit_count !== 3'd0) begin
            bad++; $display("FAIL basic_drained got empty=%b commit=%0d want empty=1 commit=0", rob_empty, commit_count);
        end
        total++;
    endtask

    task automatic test_out_of_order;
        do_reset();
        drive_alloc(3, 6'd10, 6'd11, 6'd12, 6'd0);
        tick();
        idle();
        drive_cmplt(4'b0001, 5'd2, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        if (commit_count !== 3'd0) begin bad++; $display("FAIL ooo_blocked0 got=%0d want=0", commit_count); end
        total++;
        tick();
        if (commit_count !== 3'd0) begin bad++; $display("FAIL ooo_blocked1 got=%0d want=0", commit_count); end
        total++;
        drive_cmplt(4'b0011, 5'd0, 5'd1, 5'd0, 5'd0);
        tick();
        idle();
        if (commit_count !== 3'd3) begin bad++; $display("FAIL ooo_commit got=%0d want=3", commit_count); end
        total++;
        if (cmplt_free_regs !== {6'd0, 6'd0, 6'd0, 6'd12, 6'd11, 6'd10}) begin
            bad++; $display("FAIL ooo_free got=%h want=%h", cmplt_free_regs, {6'd0, 6'd0, 6'd0, 6'd12, 6'd11, 6'd10});
        end
        total++;
        tick();
        if (rob_empty !== 1'b1) begin bad++; $display("FAIL ooo_empty got=%b want=1", rob_empty); end
        total++;
    endtask

    task automatic test_fill;
        int exp_k [6] = '{6, 6, 6, 6, 6, 2};
        logic [35:0] exp_free;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_ready c=%0d got=%b want=1", c, alloc_ready); end
            total++;
            drive_alloc(4, 6'(16 + 4*c), 6'(17 + 4*c), 6'(18 + 4*c), 6'(19 + 4*c));
            tick();
        end
        idle();
        if (rob_count !== 6'd32) begin bad++; $display("FAIL fill_count got=%0d want=32", rob_count); end
        total++;
        if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b want=0", alloc_ready); end
        total++;
        drive_alloc(4, 6'd2, 6'd2, 6'd2, 6'd2);
        tick();
        idle();
        if (rob_count !== 6'd32) begin bad++; $display("FAIL fill_overalloc got=%0d want=32", rob_count); end
        total++;
        for (int c = 0; c < 7; c++) begin
            drive_cmplt(4'hF, 5'(31 - 4*c), 5'(30 - 4*c), 5'(29 - 4*c), 5'(28 - 4*c));
            tick();
            if (commit_count !== 3'd0) begin bad++; $display("FAIL fill_hold c=%0d got=%0d want=0", c, commit_count); end
            total++;
        end
        drive_cmplt(4'hF, 5'd0, 5'd1, 5'd2, 5'd3);
        tick();
        idle();
        for (int s = 0; s < 6; s++) begin
            exp_free = '0;
            for (int j = 0; j < exp_k[s]; j++) begin
                exp_free[j*6 +: 6] = 6'(16 + 6*s + j);
            end
            if (commit_count !== 3'(exp_k[s])) begin
                bad++; $display("FAIL fill_commit s=%0d got=%0d want=%0d", s, commit_count, exp_k[s]);
            end
            total++;
            if (cmplt_free_regs !== exp_free) begin
                bad++; $display("FAIL fill_free s=%0d got=%h want=%h", s, cmplt_free_regs, exp_free);
            end
            total++;
            if (s == 0) begin
                if (alloc_ready !== 1'b0) begin bad++; $display("FAIL fill_precommit_ready got=%b want=0", alloc_ready); end
                total++;
            end
            tick();
        end
        if (rob_empty !== 1'b1 || alloc_ready !== 1'b1) begin
            bad++; $display("FAIL fill_drained got empty=%b ready=%b want 1/1", rob_empty, alloc_ready);
        end
        total++;
    endtask

    task automatic test_wrap;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive_alloc(4, 6'd1, 6'd1, 6'd1, 6'd1);
            tick();
            alloc_valid = 4'd0;
            drive_cmplt(4'hF, 5'(4*c), 5'(4*c + 1), 5'(4*c + 2), 5'(4*c + 3));
            tick();
            idle();
            tick();
        end
        drive_alloc(2, 6'd1, 6'd1, 6'd0, 6'd0);
        tick();
        alloc_valid = 4'd0;
        drive_cmplt(4'b0011, 5'd28, 5'd29, 5'd0, 5'd0);
        tick();
        idle();
        tick();
        if (rob_entries !== {5'd1, 5'd0, 5'd31, 5'd30} || rob_empty !== 1'b1) begin
            bad++; $display("FAIL wrap_pre got=%h empty=%b want=%h empty=1", rob_entries, rob_empty, {5'd1, 5'd0, 5'd31, 5'd30});
        end
        total++;
        drive_alloc(4, 6'd20, 6'd21, 6'd22, 6'd23);
        tick();
        idle();
        if (rob_entries !== {5'd5, 5'd4, 5'd3, 5'd2} || rob_count !== 6'd4) begin
            bad++; $display("FAIL wrap_alloc got=%h count=%0d want=%h count=4", rob_entries, rob_count, {5'd5, 5'd4, 5'd3, 5'd2});
        end
        total++;
        drive_cmplt(4'hF, 5'd1, 5'd31, 5'd0, 5'd30);
        tick();
        idle();
        if (commit_count !== 3'd4) begin bad++; $display("FAIL wrap_commit got=%0d want=4", commit_count); end
        total++;
        if (cmplt_free_regs !== {6'd0, 6'd0, 6'd23, 6'd22, 6'd21, 6'd20}) begin
            bad++; $display("FAIL wrap_free got=%h want=%h", cmplt_free_regs, {6'd0, 6'd0, 6'd23, 6'd22, 6'd21, 6'd20});
        end
        total++;
        tick();
        if (rob_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b want=1", rob_empty); end
        total++;
    endtask

    task automatic test_stray;
        do_reset();
        drive_alloc(2, 6'd0, 6'd1, 6'd0, 6'd0);
        tick();
        idle();
        drive_cmplt(4'b0011, 5'd5, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        if (commit_count !== 3'd1 || cmplt_free_regs !== 36'd0 || rob_count !== 6'd2) begin
            bad++; $display("FAIL stray_first got commit=%0d free=%h count=%0d want 1/0/2", commit_count, cmplt_free_regs, rob_count);
        end
        total++;
        tick();
        if (rob_count !== 6'd1 || commit_count !== 3'd0) begin
            bad++; $display("FAIL stray_after got count=%0d commit=%0d want 1/0", rob_count, commit_count);
        end
        total++;
        drive_cmplt(4'b0011, 5'd20, 5'd1, 5'd0, 5'd0);
        tick();
        idle();
        if (commit_count !== 3'd1 || cmplt_free_regs !== 36'd1) begin
            bad++; $display("FAIL stray_alias1 got commit=%0d free=%h want 1/1", commit_count, cmplt_free_regs);
        end
        total++;
        tick();
        drive_alloc(4, 6'd30, 6'd31, 6'd32, 6'd33);
        drive_cmplt(4'b0011, 5'd2, 5'd3, 5'd0, 5'd0);
        tick();
        idle();
        tick();
        if (commit_count !== 3'd0 || rob_count !== 6'd4) begin
            bad++; $display("FAIL stray_same_edge got commit=%0d count=%0d want 0/4", commit_count, rob_count);
        end
        total++;
        drive_cmplt(4'hF, 5'd2, 5'd3, 5'd4, 5'd5);
        tick();
        idle();
        if (commit_count !== 3'd4 || cmplt_free_regs !== {6'd0, 6'd0, 6'd33, 6'd32, 6'd31, 6'd30}) begin
            bad++; $display("FAIL stray_retire got commit=%0d free=%h want 4/%h", commit_count, cmplt_free_regs,
                            {6'd0, 6'd0, 6'd33, 6'd32, 6'd31, 6'd30});
        end
        total++;
        tick();
    endtask

    task automatic test_mid_reset;
        do_reset();
        drive_alloc(4, 6'd40, 6'd41, 6'd42, 6'd43);
        tick();
        drive_alloc(4, 6'd44, 6'd45, 6'd46, 6'd47);
        tick();
        drive_alloc(2, 6'd48, 6'd49, 6'd0, 6'd0);
        tick();
        idle();
        if (rob_count !== 6'd10) begin bad++; $display("FAIL midrst_live got=%0d want=10", rob_count); end
        total++;
        drive_cmplt(4'hF, 5'd0, 5'd1, 5'd2, 5'd3);
        tick();
        rst = 1'b1;
        drive_alloc(4, 6'd9, 6'd9, 6'd9, 6'd9);
        drive_cmplt(4'hF, 5'd4, 5'd5, 5'd6, 5'd7);
        tick();
        rst = 1'b0;
        idle();
        if (rob_entries !== {5'd3, 5'd2, 5'd1, 5'd0} || rob_count !== 6'd0 || rob_empty !== 1'b1 ||
            commit_count !== 3'd0 || cmplt_free_regs !== 36'd0 || alloc_ready !== 1'b1) begin
            bad++; $display("FAIL midrst_state got entries=%h count=%0d empty=%b commit=%0d free=%h ready=%b",
                            rob_entries, rob_count, rob_empty, commit_count, cmplt_free_regs, alloc_ready);
        end
        total++;
        drive_cmplt(4'hF, 5'd0, 5'd1, 5'd2, 5'd3);
        tick();
        idle();
        if (commit_count !== 3'd0 || rob_count !== 6'd0) begin
            bad++; $display("FAIL midrst_stale_cmplt got commit=%0d count=%0d want 0/0", commit_count, rob_count);
        end
        total++;
        drive_alloc(1, 6'd9, 6'd0, 6'd0, 6'd0);
        tick();
        idle();
        tick();
        if (commit_count !== 3'd0 || rob_count !== 6'd1) begin
            bad++; $display("FAIL midrst_no_done got commit=%0d count=%0d want 0/1", commit_count, rob_count);
        end
        total++;
        drive_cmplt(4'b0001, 5'd0, 5'd0, 5'd0, 5'd0);
        tick();
        idle();
        if (commit_count !== 3'd1 || cmplt_free_regs !== 36'd9) begin
            bad++; $display("FAIL midrst_fresh got commit=%0d free=%h want 1/9", commit_count, cmplt_free_regs);
        end
        total++;
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        alloc_valid     = 4'd0;
        alloc_old_alias = 24'd0;
        cmplt_valid     = 4'd0;
        cmplt_rob_id    = 20'd0;
        tick();
        tick();
        test_reset();
        test_basic();
        test_out_of_order();
        test_fill();
        test_wrap();
        test_stray();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
